// File: rtl/conv_layer_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_sched_pkg
// Description : Shared types and constants for the convolution layer
//               scheduler: FSM state encoding, index widths, plane size.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_sched_pkg;

    localparam int unsigned WIN_W = 16;   // anchor index width within a 2D plane
    localparam int unsigned IDX_W = 8;    // depth / kernel / drain counter width

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Number of anchor positions in one input plane.
    function automatic int unsigned plane_size(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_layer_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_layer_sched_if
// Description : Control / window-issue bundle between the layer controller,
//               the scheduler, the address generator and the MAC array.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_layer_sched_if;
    import conv_sched_pkg::*;

    logic             start;
    logic             abort;
    logic             ds_ready;
    logic             busy;
    logic             done;
    logic             agen_enable;
    logic             agen_pause;
    logic             win_valid;
    logic             win_last_depth;
    logic [WIN_W-1:0] win_idx;
    logic [IDX_W-1:0] depth_idx;
    logic [IDX_W-1:0] kernel_idx;

    // Controller / environment side.
    modport master (
        output start, abort, ds_ready,
        input  busy, done, agen_enable, agen_pause, win_valid, win_last_depth,
        input  win_idx, depth_idx, kernel_idx
    );

    // Scheduler side.
    modport slave (
        input  start, abort, ds_ready,
        output busy, done, agen_enable, agen_pause, win_valid, win_last_depth,
        output win_idx, depth_idx, kernel_idx
    );

endinterface
`default_nettype wire

// File: rtl/sched_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : sched_wrap_counter
// Description : Wrapping index counter 0..MAX with synchronous clear and a
//               terminal-count carry flag, chained to build index nests.
// Revision    : 1.0 - initial release
// ============================================================================
module sched_wrap_counter
    import conv_sched_pkg::*;
#(
    parameter int unsigned WIDTH = IDX_W,
    parameter int unsigned MAX   = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             inc,
    input  wire logic             clr,
    output logic      [WIDTH-1:0] count,
    output logic                  carry
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Count up on inc, wrapping past MAX; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= (r_count == c_MAX) ? '0 : r_count + c_ONE;
        end
    end

    // carry flags the terminal value: the next inc wraps and should advance
    // the next counter of the nest.
    assign count = r_count;
    assign carry = (r_count == c_MAX);

endmodule
`default_nettype wire

// File: rtl/conv_layer_sched.sv
`default_nettype none
// ============================================================================
// Module      : conv_layer_sched
// Description : Sequences one convolution layer: start/done handshake,
//               address-generator enable/pause, window/depth/kernel nest,
//               downstream backpressure and MAC pipeline drain.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_layer_sched
    import conv_sched_pkg::*;
#(
    parameter int unsigned ANCHOR_W   = 31,
    parameter int unsigned ANCHOR_H   = 31,
    parameter int unsigned DATA_DEPTH = 1,
    parameter int unsigned KERNEL_NUM = 6,
    parameter int unsigned PIPE_LAT   = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    conv_layer_sched_if.slave  bus
);

    localparam int unsigned      c_PLANE      = plane_size(ANCHOR_W, ANCHOR_H);
    localparam int unsigned      c_DRAIN_INT  = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;
    localparam logic [IDX_W-1:0] c_DRAIN_LAST = IDX_W'(c_DRAIN_INT);
    localparam logic [IDX_W-1:0] c_ONE        = IDX_W'(1);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_agen_enable;
    logic [IDX_W-1:0] r_drain_cnt;

    logic             w_run;
    logic             w_issue;
    logic             w_final;
    logic             w_clr;
    logic             w_win_inc;
    logic             w_win_max;
    logic             w_dep_max;
    logic             w_ker_max;
    logic [WIN_W-1:0] w_win_idx;
    logic [IDX_W-1:0] w_depth_idx;
    logic [IDX_W-1:0] w_kernel_idx;

    // A window issues whenever RUN sees downstream room; an abort in the
    // same cycle cancels the issue so the indices hold where they were.
    assign w_run     = (r_state == S_RUN);
    assign w_issue   = w_run && bus.ds_ready && !bus.abort;
    assign w_final   = w_issue && w_win_max && w_dep_max && w_ker_max;
    assign w_clr     = (r_state == S_IDLE) && bus.start && !bus.abort;
    // The final issue does not advance the nest, leaving the indices on the
    // last window until the next start.
    assign w_win_inc = w_issue && !w_final;

    sched_wrap_counter #(.WIDTH(WIN_W), .MAX(c_PLANE - 1)) u_win_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_win_inc),
        .clr   (w_clr),
        .count (w_win_idx),
        .carry (w_win_max)
    );

    sched_wrap_counter #(.WIDTH(IDX_W), .MAX(DATA_DEPTH - 1)) u_depth_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_win_inc && w_win_max),
        .clr   (w_clr),
        .count (w_depth_idx),
        .carry (w_dep_max)
    );

    sched_wrap_counter #(.WIDTH(IDX_W), .MAX(KERNEL_NUM - 1)) u_kernel_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_win_inc && w_win_max && w_dep_max),
        .clr   (w_clr),
        .count (w_kernel_idx),
        .carry (w_ker_max)
    );

    // Layer FSM with registered busy/done/agen_enable; abort overrides all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_agen_enable <= 1'b0;
            r_drain_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE && bus.abort) begin
                r_state       <= S_IDLE;
                r_busy        <= 1'b0;
                r_agen_enable <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_clr) begin
                            r_state       <= S_RUN;
                            r_busy        <= 1'b1;
                            r_agen_enable <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (w_final) begin
                            // Dropping enable here resets the agen window counter.
                            r_agen_enable <= 1'b0;
                            r_drain_cnt   <= '0;
                            if (PIPE_LAT > 0) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (r_drain_cnt == c_DRAIN_LAST) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + c_ONE;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.agen_enable    = r_agen_enable;
    assign bus.agen_pause     = w_run ? !bus.ds_ready : 1'b1;
    assign bus.win_valid      = w_issue;
    assign bus.win_last_depth = w_issue && w_dep_max;
    assign bus.win_idx        = w_win_idx;
    assign bus.depth_idx      = w_depth_idx;
    assign bus.kernel_idx     = w_kernel_idx;

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_layer_sched
// Description : Self-checking bench: two builds (PIPE_LAT=3 and PIPE_LAT=0)
//               share stimulus; an issue-count model predicts every output
//               each cycle, and per-scenario literal expectations pin it.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_conv_layer_sched;
    import conv_sched_pkg::*;

    localparam int AW = 2, AH = 2, DD = 2, KN = 2;
    localparam int P     = AW * AH;
    localparam int TOTAL = P * DD * KN;
    localparam int PL0 = 3, PL1 = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic t_start = 1'b0, t_abort = 1'b0, t_ready = 1'b0;

    conv_layer_sched_if if0();
    conv_layer_sched_if if1();
    assign if0.start = t_start;  assign if0.abort = t_abort;  assign if0.ds_ready = t_ready;
    assign if1.start = t_start;  assign if1.abort = t_abort;  assign if1.ds_ready = t_ready;

    conv_layer_sched #(.ANCHOR_W(AW), .ANCHOR_H(AH), .DATA_DEPTH(DD), .KERNEL_NUM(KN),
                       .PIPE_LAT(PL0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    conv_layer_sched #(.ANCHOR_W(AW), .ANCHOR_H(AH), .DATA_DEPTH(DD), .KERNEL_NUM(KN),
                       .PIPE_LAT(PL1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    logic             a_busy[2], a_done[2], a_en[2], a_pause[2], a_wv[2], a_wld[2];
    logic [WIN_W-1:0] a_wi[2];
    logic [IDX_W-1:0] a_di[2], a_ki[2];
    assign a_busy[0] = if0.busy;        assign a_busy[1] = if1.busy;
    assign a_done[0] = if0.done;        assign a_done[1] = if1.done;
    assign a_en[0]   = if0.agen_enable; assign a_en[1]   = if1.agen_enable;
    assign a_pause[0]= if0.agen_pause;  assign a_pause[1]= if1.agen_pause;
    assign a_wv[0]   = if0.win_valid;   assign a_wv[1]   = if1.win_valid;
    assign a_wld[0]  = if0.win_last_depth; assign a_wld[1] = if1.win_last_depth;
    assign a_wi[0]   = if0.win_idx;     assign a_wi[1]   = if1.win_idx;
    assign a_di[0]   = if0.depth_idx;   assign a_di[1]   = if1.depth_idx;
    assign a_ki[0]   = if0.kernel_idx;  assign a_ki[1]   = if1.kernel_idx;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0    = 0;
    bit mon_clr = 1'b0;
    bit lit_go  = 1'b0;
    int scen    = 0;

    // Reference model: a layer is "running" from start until done; k counts
    // windows issued; post counts cycles since the last issue.
    bit m_run[2]  = '{1'b0, 1'b0};
    int m_k[2]    = '{0, 0};
    int m_post[2] = '{0, 0};
    int pl[2]     = '{PL0, PL1};

    // Per-run observations for the literal expectations.
    int n_iss[2], n_wld[2], f_d1[2], f_k1[2], done_rel[2], last_en[2], last_busy[2];

    always @(posedge clk) cyc <= cyc + 1;

    // Advance the reference model on each clock edge, reset asynchronously.
    always @(posedge clk or negedge rst_n) begin
        for (int b = 0; b < 2; b++) begin
            if (!rst_n) begin
                m_run[b] <= 1'b0; m_k[b] <= 0; m_post[b] <= 0;
            end else if (!m_run[b]) begin
                if (t_start && !t_abort) begin
                    m_run[b] <= 1'b1; m_k[b] <= 0; m_post[b] <= 0;
                end
            end else if (t_abort) begin
                m_run[b] <= 1'b0;
            end else if (m_k[b] < TOTAL) begin
                if (t_ready) begin
                    m_k[b] <= m_k[b] + 1;
                    if (m_k[b] == TOTAL - 1) m_post[b] <= 1;
                end
            end else if (m_post[b] == pl[b] + 1) begin
                m_run[b] <= 1'b0;
            end else begin
                m_post[b] <= m_post[b] + 1;
            end
        end
    end

    task automatic chk(input string name, input int b, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s build%0d cyc %0d: got %0d expected %0d", name, b, cyc - t0, act, exp);
        end
    endtask

    // Single compare process: model vs DUT every cycle, run bookkeeping,
    // and literal expectations when the stimulus requests them.
    always @(negedge clk) begin
        for (int b = 0; b < 2; b++) begin
            bit inrun;
            bit e_wv;
            int k;
            inrun = m_run[b] && (m_k[b] < TOTAL);
            k     = (m_k[b] >= TOTAL) ? TOTAL - 1 : m_k[b];
            e_wv  = inrun && t_ready && !t_abort;
            chk("busy",        b, int'(a_busy[b]),  int'(m_run[b]));
            chk("done",        b, int'(a_done[b]),  int'(m_run[b] && m_k[b] == TOTAL && m_post[b] == pl[b] + 1));
            chk("agen_enable", b, int'(a_en[b]),    int'(inrun));
            chk("agen_pause",  b, int'(a_pause[b]), int'(inrun ? !t_ready : 1'b1));
            chk("win_valid",   b, int'(a_wv[b]),    int'(e_wv));
            chk("win_last_depth", b, int'(a_wld[b]), int'(e_wv && ((k / P) % DD) == DD - 1));
            chk("win_idx",     b, int'(a_wi[b]),    k % P);
            chk("depth_idx",   b, int'(a_di[b]),    (k / P) % DD);
            chk("kernel_idx",  b, int'(a_ki[b]),    k / (P * DD));

            if (mon_clr) begin
                n_iss[b] <= 0; n_wld[b] <= 0; f_d1[b] <= -1; f_k1[b] <= -1;
                done_rel[b] <= -1; last_en[b] <= -1; last_busy[b] <= -1;
            end else begin
                if (a_wv[b]) begin
                    n_iss[b] <= n_iss[b] + 1;
                    if (a_wld[b]) n_wld[b] <= n_wld[b] + 1;
                    if (a_di[b] == 1 && f_d1[b] < 0) f_d1[b] <= n_iss[b] + 1;
                    if (a_ki[b] == 1 && f_k1[b] < 0) f_k1[b] <= n_iss[b] + 1;
                end
                if (a_done[b]) done_rel[b]  <= cyc - t0;
                if (a_en[b])   last_en[b]   <= cyc - t0;
                if (a_busy[b]) last_busy[b] <= cyc - t0;
            end
        end

        if (lit_go) begin
            case (scen)
                1: begin
                    chk("steady_done_cycle", 0, done_rel[0], 20);
                    chk("steady_done_cycle", 1, done_rel[1], 17);
                    chk("steady_issues", 0, n_iss[0], 16);
                    chk("steady_issues", 1, n_iss[1], 16);
                    chk("depth1_first_issue", 0, f_d1[0], 5);
                    chk("kernel1_first_issue", 0, f_k1[0], 9);
                    chk("last_depth_count", 0, n_wld[0], 8);
                    chk("last_enable_cycle", 0, last_en[0], 16);
                    chk("last_busy_cycle", 0, last_busy[0], 20);
                    chk("last_busy_cycle", 1, last_busy[1], 17);
                end
                2: begin
                    chk("bp_done_cycle", 0, done_rel[0], 23);
                    chk("bp_done_cycle", 1, done_rel[1], 20);
                    chk("bp_issues", 0, n_iss[0], 16);
                end
                3: begin
                    chk("abort_no_done", 0, done_rel[0], -1);
                    chk("abort_no_done", 1, done_rel[1], -1);
                    chk("abort_last_busy", 0, last_busy[0], 6);
                    chk("abort_last_enable", 0, last_en[0], 6);
                end
                4: begin
                    chk("restart_done_cycle", 0, done_rel[0], 20);
                    chk("restart_issues", 0, n_iss[0], 16);
                    chk("restart_depth1_issue", 0, f_d1[0], 5);
                end
                5: begin
                    chk("dupstart_done_cycle", 0, done_rel[0], 20);
                    chk("dupstart_issues", 0, n_iss[0], 16);
                end
                6: begin
                    chk("reset_no_done", 0, done_rel[0], -1);
                    chk("reset_issues", 0, n_iss[0], 9);
                    chk("reset_last_busy", 0, last_busy[0], 9);
                end
                default: ;
            endcase
        end
    end

    // One layer: start in cycle 0, then n_cyc cycles of scripted or random inputs.
    task automatic run_layer(input int id, input int n_cyc, input int bp_lo, input int bp_hi,
                             input int abort_at, input int dup_at, input int rst_at, input bit rnd);
        @(posedge clk); #1;
        mon_clr = 1'b1; t_start = 1'b0; t_abort = 1'b0; t_ready = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0; t0 = cyc; t_start = 1'b1;
        for (int c = 1; c <= n_cyc; c++) begin
            @(posedge clk); #1;
            rst_n   = (c == rst_at) ? 1'b0 : 1'b1;
            t_start = (c == dup_at) || (rnd && $urandom_range(0, 19) == 0);
            t_abort = (c == abort_at) || (rnd && $urandom_range(0, 59) == 0);
            t_ready = rnd ? ($urandom_range(0, 3) != 0) : !(c >= bp_lo && c <= bp_hi);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; t_start = 1'b0; t_abort = 1'b0; t_ready = 1'b1;
        scen = id; lit_go = 1'b1;
        @(negedge clk); #1;
        lit_go = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_layer(1, 25, -1, -1, -1, -1, -1, 1'b0);   // steady flow
        run_layer(2, 28,  5,  7, -1, -1, -1, 1'b0);   // backpressure
        run_layer(3, 15, -1, -1,  6, -1, -1, 1'b0);   // abort mid-run
        run_layer(4, 25, -1, -1, -1, -1, -1, 1'b0);   // restart after abort
        run_layer(5, 25, -1, -1, -1,  8, -1, 1'b0);   // start while busy
        run_layer(6, 15, -1, -1, -1, -1, 10, 1'b0);   // reset mid-run
        for (int i = 0; i < 8; i++) run_layer(7, 60, -1, -1, -1, -1, -1, 1'b1);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
